// File: rtl/pipe_stage_skid.sv
`timescale 1ns/1ps
// Two-entry skid-buffered pipeline stage (main + skid register) with flush,
// global enable and a completed-transfer counter.
module pipe_stage_skid #(
  parameter int PAYLOAD_W = 69,
  parameter int CTRL_W    = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  input  logic [CTRL_W-1:0]    in_ctrl_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_payload_o,
  output logic [CTRL_W-1:0]    out_ctrl_o,
  output logic [CNT_W-1:0]     xfer_cnt_o,
  output logic [1:0]           state_o
);

  // Handshake: an entry moves on a rising edge when valid and ready are both
  // high (and the stage is enabled and not flushing); valid never waits on
  // ready, and in_ready_o depends on registered state only.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PAYLOAD_W-1:0]   main_payload_q, main_payload_d;
  logic [CTRL_W-1:0]      main_ctrl_q, main_ctrl_d;
  logic [PAYLOAD_W-1:0]   skid_payload_q, skid_payload_d;
  logic [CTRL_W-1:0]      skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   accept, take;

  assign in_ready_o    = (state_q != FULL);
  assign out_valid_o   = (state_q != EMPTY);
  assign out_payload_o = main_payload_q;
  // Bubble control bits whenever the head is not valid.
  assign out_ctrl_o    = out_valid_o ? main_ctrl_q : '0;
  assign xfer_cnt_o    = cnt_q;
  assign state_o       = state_q;

  assign accept = in_valid_i & in_ready_o & start_i & ~flush_i;
  assign take   = out_valid_o & out_ready_i & start_i & ~flush_i;

  always_comb begin
    state_d        = state_q;
    main_payload_d = main_payload_q;
    main_ctrl_d    = main_ctrl_q;
    skid_payload_d = skid_payload_q;
    skid_ctrl_d    = skid_ctrl_q;
    cnt_d          = cnt_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_payload_d = in_payload_i;
            main_ctrl_d    = in_ctrl_i;
            state_d        = ONE;
          end
        end
        ONE: begin
          if (accept && take) begin
            main_payload_d = in_payload_i;
            main_ctrl_d    = in_ctrl_i;
          end else if (accept) begin
            skid_payload_d = in_payload_i;
            skid_ctrl_d    = in_ctrl_i;
            state_d        = FULL;
          end else if (take) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (take) begin
            main_payload_d = skid_payload_q;
            main_ctrl_d    = skid_ctrl_q;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
      if (take) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= EMPTY;
      main_payload_q <= '0;
      main_ctrl_q    <= '0;
      skid_payload_q <= '0;
      skid_ctrl_q    <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      main_payload_q <= main_payload_d;
      main_ctrl_q    <= main_ctrl_d;
      skid_payload_q <= skid_payload_d;
      skid_ctrl_q    <= skid_ctrl_d;
      cnt_q          <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
`timescale 1ns/1ps
// Directed + random bench for pipe_stage_skid: occupancy model and an
// in-order expected queue checked every cycle.
module tb_pipe_stage_skid;

  localparam int PW = 69;
  localparam int CW = 4;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          flush;
  logic          in_valid;
  logic          in_ready_o;
  logic [PW-1:0] in_payload;
  logic [CW-1:0] in_ctrl;
  logic          out_valid_o;
  logic          out_ready;
  logic [PW-1:0] out_payload_o;
  logic [CW-1:0] out_ctrl_o;
  logic [NW-1:0] xfer_cnt_o;
  logic [1:0]    state_o;

  pipe_stage_skid #(.PAYLOAD_W(PW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready_o),
    .in_payload_i (in_payload),
    .in_ctrl_i    (in_ctrl),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready),
    .out_payload_o(out_payload_o),
    .out_ctrl_o   (out_ctrl_o),
    .xfer_cnt_o   (xfer_cnt_o),
    .state_o      (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [PW+CW-1:0] exp_q[$];
  logic [NW-1:0]    m_cnt;
  logic [PW-1:0]    m_last;
  logic             last_acc;
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check all outputs against the model, then advance one clock edge.
  task automatic cycle();
    logic m_ready, m_valid, m_take;
    logic [PW+CW-1:0] head;
    m_ready = (exp_q.size() < 2);
    m_valid = (exp_q.size() > 0);
    head    = m_valid ? exp_q[0] : '0;
    check("in_ready", 80'(in_ready_o), 80'(m_ready));
    check("out_valid", 80'(out_valid_o), 80'(m_valid));
    check("state", 80'(state_o), 80'(exp_q.size()));
    check("xfer_cnt", 80'(xfer_cnt_o), 80'(m_cnt));
    if (m_valid) begin
      check("out_payload", 80'(out_payload_o), 80'(head[PW-1:0]));
      check("out_ctrl", 80'(out_ctrl_o), 80'(head[PW+CW-1:PW]));
      m_last = head[PW-1:0];
    end else begin
      check("held_payload", 80'(out_payload_o), 80'(m_last));
      check("bubble_ctrl", 80'(out_ctrl_o), 80'(0));
    end
    last_acc = in_valid && m_ready && start && !flush && !rst;
    m_take   = m_valid && out_ready && start && !flush && !rst;
    @(posedge clk);
    #1;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (m_take) begin
        void'(exp_q.pop_front());
        m_cnt++;
      end
      if (last_acc) exp_q.push_back({in_ctrl, in_payload});
    end
  endtask

  // Upstream holds the entry until it is accepted.
  task automatic offer(input logic [PW-1:0] p, input logic [CW-1:0] c);
    in_valid   = 1'b1;
    in_payload = p;
    in_ctrl    = c;
    last_acc   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) begin
      n_fail++;
      $error("FAIL offer_timeout observed=not_accepted expected=accepted");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) cycle();
    cycle();
  endtask

  function automatic logic [PW-1:0] rand_payload();
    logic [PW-1:0] p;
    logic [31:0] hi;
    hi = $urandom;
    p  = {hi[4:0], $urandom, $urandom};
    return p;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_payload = '0; in_ctrl = '0; out_ready = 1'b0;
    m_cnt = '0; m_last = '0; last_acc = 1'b0;

    // Reset state
    #1;
    cycle();
    cycle();
    #4;
    rst = 1'b0;
    start = 1'b1;

    // Streaming 1..5 with out_ready high
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid   = 1'b1;
      in_payload = PW'(i);
      in_ctrl    = CW'(i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("stream_cnt", 80'(xfer_cnt_o), 80'(5));

    // Backpressure: A, B fill the stage, C waits upstream
    out_ready = 1'b0;
    offer(69'h0A, 4'h1);
    offer(69'h0B, 4'h2);
    in_valid = 1'b1; in_payload = 69'h0C; in_ctrl = 4'h3;
    cycle();
    cycle();
    check("bp_not_ready", 80'(in_ready_o), 80'(0));
    out_ready = 1'b1;
    offer(69'h0C, 4'h3);
    drain();

    // Flush while FULL
    out_ready = 1'b0;
    offer(69'h1D1, 4'b1111);
    offer(69'h1D2, 4'b1111);
    in_valid = 1'b1; in_payload = 69'h1D3; out_ready = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_valid", 80'(out_valid_o), 80'(0));
    check("flush_ctrl", 80'(out_ctrl_o), 80'(0));
    check("flush_cnt", 80'(xfer_cnt_o), 80'(8));
    cycle();

    // Freeze in ONE, then flush while frozen
    offer(69'h2E, 4'h5);
    start = 1'b0; in_valid = 1'b1; in_payload = 69'h2F; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0; start = 1'b1;
    cycle();

    // Long stream forcing counter wrap (8 -> past 15 -> 0 -> 1 ...)
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid   = 1'b1;
      in_payload = rand_payload();
      in_ctrl    = CW'($urandom_range(15, 0));
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("wrap_cnt", 80'(xfer_cnt_o), 80'(4));

    // Random valid/ready traffic
    for (int i = 0; i < 60; i++) begin
      in_valid   = 1'($urandom_range(1, 0));
      out_ready  = 1'($urandom_range(1, 0));
      in_payload = rand_payload();
      in_ctrl    = CW'($urandom_range(15, 0));
      cycle();
    end
    drain();

    // Asynchronous reset between edges while FULL
    out_ready = 1'b0;
    offer(69'h3A, 4'h6);
    offer(69'h3B, 4'h7);
    #2;
    rst = 1'b1;
    #1;
    check("rst_valid", 80'(out_valid_o), 80'(0));
    check("rst_ctrl", 80'(out_ctrl_o), 80'(0));
    check("rst_payload", 80'(out_payload_o), 80'(0));
    check("rst_ready", 80'(in_ready_o), 80'(1));
    check("rst_cnt", 80'(xfer_cnt_o), 80'(0));
    exp_q.delete();
    m_cnt = '0;
    m_last = '0;
    #1;
    rst = 1'b0;
    in_valid = 1'b1; in_payload = 69'hAB; in_ctrl = 4'h9;
    cycle();
    in_valid = 1'b0;
    check("post_rst_payload", 80'(out_payload_o), 80'h0AB);
    cycle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
